// File: rtl/addr_adder_arbiter.sv
// Round-robin share of one address adder between branch-target (req0) and base+offset (req1) requesters.
// Sum registered one cycle after accept; accepts while draining, holds result and grants nothing under res_ready=0.
module addr_adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic [7:0]       busy_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] data;
  } res_t;

  state_t           state, state_nxt;
  res_t             res_q;
  logic             rr_ptr;
  logic             can_accept;
  logic             grant_vld;
  logic             grant_id;
  logic             both_vld;
  logic [WIDTH-1:0] op_a, op_b, sum;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant_vld) state_nxt = FULL;
      FULL:    if (!grant_vld && res_ready) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Readies are suppressed during reset so no beat is handed over only to be discarded.
  always_comb begin
    both_vld   = req0_valid && req1_valid;
    can_accept = !reset && ((state == EMPTY) || res_ready);
    grant_id   = both_vld ? rr_ptr : req1_valid;
    grant_vld  = can_accept && (req0_valid || req1_valid);
    req0_ready = grant_vld && !grant_id;
    req1_ready = grant_vld && grant_id;
  end

  assign op_a = grant_id ? req1_a : req0_a;
  assign op_b = grant_id ? req1_b : req0_b;
  assign sum  = op_a + op_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q    <= '0;
      rr_ptr   <= 1'b0;
      busy_cnt <= 8'd0;
    end else begin
      if (grant_vld) res_q <= '{id: grant_id, data: sum};
      if (grant_vld && both_vld) rr_ptr <= ~grant_id;
      if ((state == FULL) && !res_ready && (busy_cnt != 8'd255))
        busy_cnt <= busy_cnt + 8'd1;
    end
  end

  assign res_valid = (state == FULL);
  assign res_id    = res_q.id;
  assign res_data  = res_q.data;

endmodule
